// File: rtl/cheat_loader_if.sv
// cheat_loader_if: HPS ioctl download port.
// Host drives the stream, loader back-pressures with ioctl_wait.
interface cheat_loader_if #(
   parameter int IOADDR_WIDTH = 25
);
   logic                    cheat_download;
   logic                    ioctl_wr;
   logic [IOADDR_WIDTH-1:0] ioctl_addr;
   logic [15:0]             ioctl_dout;
   logic                    ioctl_wait;

   modport master (
      output cheat_download,
      output ioctl_wr,
      output ioctl_addr,
      output ioctl_dout,
      input  ioctl_wait
   );

   modport slave (
      input  cheat_download,
      input  ioctl_wr,
      input  ioctl_addr,
      input  ioctl_dout,
      output ioctl_wait
   );
endinterface

// File: rtl/cheat_loader.sv
// cheat_loader: assembles 16-byte cheat codes from the ioctl
// stream and strobes them into the 32/16 cheat engine.
module cheat_loader #(
   parameter int MAX_CODES    = 32,
   parameter int CLEAR_CYCLES = 4,
   parameter int HOLD_CYCLES  = 2,
   parameter int IOADDR_WIDTH = 25,
   localparam int CW = $clog2(MAX_CODES + 1)
) (
   input  logic          clk,
   input  logic          reset_n,
   cheat_loader_if.slave ioctl,
   output logic          engine_reset,
   output logic [128:0]  code,
   output logic [CW-1:0] code_count,
   output logic          overflow
);

   localparam int TMAX = (CLEAR_CYCLES > HOLD_CYCLES) ?
                         CLEAR_CYCLES : HOLD_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      COLLECT,
      STB_HI,
      STB_LO
   } state_t;

   state_t          state_q;
   logic [TW-1:0]   tmr_q;
   logic            dl_q;
   logic            er_q;
   logic            wait_q;
   logic            stb_q;
   logic [127:0]    buf_q;
   logic [CW-1:0]   cnt_q;
   logic            ovf_q;

   logic            dl;
   logic            dl_rise;
   logic [2:0]      w;
   logic [2:0]      lane;
   logic [6:0]      lo;
   logic            last_clr;
   logic            last_hold;
   logic            room;
   logic            addr_unused;

   assign dl        = ioctl.cheat_download;
   assign dl_rise   = dl & ~dl_q;
   assign w         = ioctl.ioctl_addr[3:1];
   // field f = w>>1 sits at 32*(3-f); odd words fill the upper half
   assign lane      = {~w[2:1], w[0]};
   assign lo        = {lane, 4'b0000};
   assign last_clr  = (tmr_q == TW'(CLEAR_CYCLES - 1));
   assign last_hold = (tmr_q == TW'(HOLD_CYCLES - 1));
   assign room      = (cnt_q < CW'(MAX_CODES));

   // only the word index within a 16-byte code matters
   assign addr_unused = ^{ioctl.ioctl_addr[IOADDR_WIDTH-1:4],
                          ioctl.ioctl_addr[0]};

   assign ioctl.ioctl_wait = wait_q;
   assign engine_reset     = er_q;
   assign code             = {stb_q, buf_q};
   assign code_count       = cnt_q;
   assign overflow         = ovf_q;

   // download sequencer with registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         tmr_q   <= '0;
         // treat a download already active at reset as old
         dl_q    <= 1'b1;
         er_q    <= 1'b0;
         wait_q  <= 1'b0;
         stb_q   <= 1'b0;
         buf_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         dl_q <= dl;
         if (dl_rise) begin
            state_q <= CLEAR;
            tmr_q   <= '0;
            er_q    <= 1'b1;
            wait_q  <= 1'b1;
            stb_q   <= 1'b0;
            buf_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
         end else begin
            unique case (state_q)
               IDLE: begin
                  tmr_q <= '0;
               end
               CLEAR: begin
                  if (last_clr) begin
                     er_q    <= 1'b0;
                     wait_q  <= 1'b0;
                     tmr_q   <= '0;
                     state_q <= dl ? COLLECT : IDLE;
                  end else begin
                     tmr_q <= tmr_q + 1'b1;
                  end
               end
               COLLECT: begin
                  if (!dl) begin
                     // download aborted: drop the partial code
                     buf_q   <= '0;
                     state_q <= IDLE;
                  end else if (ioctl.ioctl_wr) begin
                     buf_q[lo +: 16] <= ioctl.ioctl_dout;
                     if (w == 3'd7) begin
                        if (room) begin
                           stb_q   <= 1'b1;
                           wait_q  <= 1'b1;
                           tmr_q   <= '0;
                           state_q <= STB_HI;
                        end else begin
                           ovf_q <= 1'b1;
                        end
                     end
                  end
               end
               STB_HI: begin
                  if (last_hold) begin
                     stb_q   <= 1'b0;
                     cnt_q   <= cnt_q + 1'b1;
                     tmr_q   <= '0;
                     state_q <= STB_LO;
                  end else begin
                     tmr_q <= tmr_q + 1'b1;
                  end
               end
               STB_LO: begin
                  if (last_hold) begin
                     wait_q  <= 1'b0;
                     tmr_q   <= '0;
                     state_q <= dl ? COLLECT : IDLE;
                  end else begin
                     tmr_q <= tmr_q + 1'b1;
                  end
               end
               default: begin
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cheat_loader.sv
// tb_cheat_loader: directed vectors for cheat_loader.
// Inputs change 1 ns after posedge; outputs checked there too.
module tb_cheat_loader;

   logic         clk;
   logic         reset_n;
   logic         engine_reset;
   logic [128:0] code;
   logic [5:0]   code_count;
   logic         overflow;

   int n_tests;
   int n_fail;
   int n_stb;
   logic stb_prev;
   int s0;
   int s1;

   cheat_loader_if #(.IOADDR_WIDTH(25)) bus ();

   cheat_loader dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .ioctl        (bus.slave),
      .engine_reset (engine_reset),
      .code         (code),
      .code_count   (code_count),
      .overflow     (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // count rising edges of the engine code clock
   initial begin
      n_stb    = 0;
      stb_prev = 1'b0;
   end
   always @(negedge clk) begin
      if (code[128] && !stb_prev) n_stb = n_stb + 1;
      stb_prev = code[128];
   end

   task automatic check(input string tag,
                        input logic [159:0] got,
                        input logic [159:0] exp);
      n_tests = n_tests + 1;
      if (got !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] word_of(int base, int w);
      logic [7:0] b0;
      logic [7:0] b1;
      b0 = 8'(base + 2 * w);
      b1 = 8'(base + 2 * w + 1);
      return {b1, b0};
   endfunction

   // big-endian engine layout: flags, address, compare, replace
   function automatic logic [127:0] exp_code(int base);
      logic [127:0] e;
      logic [31:0]  f32;
      e = '0;
      for (int f = 0; f < 4; f++) begin
         f32 = {8'(base + 4 * f + 3), 8'(base + 4 * f + 2),
                8'(base + 4 * f + 1), 8'(base + 4 * f)};
         e = {e[95:0], f32};
      end
      return e;
   endfunction

   task automatic write_word(input int addr, input logic [15:0] d);
      bus.ioctl_wr   = 1'b1;
      bus.ioctl_addr = 25'(addr);
      bus.ioctl_dout = d;
      tick();
      bus.ioctl_wr   = 1'b0;
   endtask

   task automatic send_code(input int base, input int idx);
      for (int w = 0; w < 8; w++)
         write_word(idx * 16 + 2 * w, word_of(base, w));
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 12 && bus.ioctl_wait; i++) tick();
      check("wait_release", 160'(bus.ioctl_wait), 160'(0));
   endtask

   task automatic start_download();
      bus.cheat_download = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("clr_er", 160'(engine_reset), 160'(1));
         check("clr_wait", 160'(bus.ioctl_wait), 160'(1));
      end
      tick();
      check("clr_er_end", 160'(engine_reset), 160'(0));
      check("clr_wait_end", 160'(bus.ioctl_wait), 160'(0));
      check("clr_count", 160'(code_count), 160'(0));
      check("clr_ovf", 160'(overflow), 160'(0));
   endtask

   initial begin
      int order [8];
      n_tests = 0;
      n_fail  = 0;
      reset_n = 1'b0;
      bus.cheat_download = 1'b0;
      bus.ioctl_wr   = 1'b0;
      bus.ioctl_addr = '0;
      bus.ioctl_dout = '0;
      order = '{3, 1, 0, 2, 5, 4, 6, 7};

      repeat (3) tick();
      check("rst_er", 160'(engine_reset), 160'(0));
      check("rst_wait", 160'(bus.ioctl_wait), 160'(0));
      check("rst_code", 160'(code), 160'(0));
      check("rst_count", 160'(code_count), 160'(0));
      check("rst_ovf", 160'(overflow), 160'(0));
      reset_n = 1'b1;
      tick();
      check("idle_er", 160'(engine_reset), 160'(0));

      start_download();

      // code 1: bytes 00..0F in order
      s0 = n_stb;
      send_code(0, 0);
      check("c1_stb_t1", 160'(code[128]), 160'(1));
      check("c1_data", 160'(code[127:0]),
            160'(128'h03020100_07060504_0B0A0908_0F0E0D0C));
      check("c1_wait_t1", 160'(bus.ioctl_wait), 160'(1));
      tick();
      check("c1_stb_t2", 160'(code[128]), 160'(1));
      check("c1_cnt_t2", 160'(code_count), 160'(0));
      tick();
      check("c1_stb_t3", 160'(code[128]), 160'(0));
      check("c1_cnt_t3", 160'(code_count), 160'(1));
      tick();
      check("c1_stb_t4", 160'(code[128]), 160'(0));
      check("c1_wait_t4", 160'(bus.ioctl_wait), 160'(1));
      tick();
      check("c1_wait_t5", 160'(bus.ioctl_wait), 160'(0));
      check("c1_nstb", 160'(n_stb - s0), 160'(1));

      // code 2: out-of-order words, write attempted during wait
      for (int i = 0; i < 8; i++)
         write_word(16 + 2 * order[i], word_of(16, order[i]));
      write_word(16, 16'hFFFF);
      check("c2_stb_t2", 160'(code[128]), 160'(1));
      check("c2_data", 160'(code[127:0]), 160'(exp_code(16)));
      tick();
      check("c2_stb_t3", 160'(code[128]), 160'(0));
      check("c2_cnt_t3", 160'(code_count), 160'(2));
      tick();
      check("c2_wait_t4", 160'(bus.ioctl_wait), 160'(1));
      tick();
      check("c2_wait_t5", 160'(bus.ioctl_wait), 160'(0));
      check("c2_hold", 160'(code[127:0]), 160'(exp_code(16)));

      // codes 3..32 fill the engine
      for (int k = 2; k < 32; k++) begin
         send_code((k * 7) & 255, k);
         wait_idle();
      end
      check("full_count", 160'(code_count), 160'(32));
      check("full_ovf", 160'(overflow), 160'(0));
      check("full_nstb", 160'(n_stb - s0), 160'(32));
      check("full_data", 160'(code[127:0]), 160'(exp_code(217)));

      // code 33 is dropped
      send_code(100, 32);
      check("ovf_wait", 160'(bus.ioctl_wait), 160'(0));
      check("ovf_stb", 160'(code[128]), 160'(0));
      check("ovf_flag", 160'(overflow), 160'(1));
      check("ovf_count", 160'(code_count), 160'(32));
      tick();
      check("ovf_nstb", 160'(n_stb - s0), 160'(32));

      // partial code then abort
      bus.cheat_download = 1'b0;
      repeat (2) tick();
      start_download();
      for (int w = 0; w < 6; w++)
         write_word(2 * w, word_of(0, w));
      bus.cheat_download = 1'b0;
      repeat (2) tick();
      s1 = n_stb;
      write_word(14, 16'h0F0E);
      tick();
      check("abort_stb", 160'(code[128]), 160'(0));
      check("abort_wait", 160'(bus.ioctl_wait), 160'(0));
      check("abort_count", 160'(code_count), 160'(0));
      check("abort_nstb", 160'(n_stb - s1), 160'(0));

      // restart download during a strobe
      start_download();
      send_code(64, 0);
      wait_idle();
      check("rs_count1", 160'(code_count), 160'(1));
      send_code(80, 1);
      check("rs_stb_t1", 160'(code[128]), 160'(1));
      bus.cheat_download = 1'b0;
      tick();
      check("rs_stb_t2", 160'(code[128]), 160'(1));
      bus.cheat_download = 1'b1;
      tick();
      check("rs_stb_t3", 160'(code[128]), 160'(0));
      check("rs_count", 160'(code_count), 160'(0));
      check("rs_er_t3", 160'(engine_reset), 160'(1));
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rs_er", 160'(engine_reset), 160'(1));
      end
      tick();
      check("rs_er_end", 160'(engine_reset), 160'(0));
      check("rs_wait_end", 160'(bus.ioctl_wait), 160'(0));

      // asynchronous reset in the middle of a strobe
      send_code(96, 0);
      wait_idle();
      send_code(112, 1);
      check("mr_stb_pre", 160'(code[128]), 160'(1));
      reset_n = 1'b0;
      #1;
      check("mr_code", 160'(code), 160'(0));
      check("mr_wait", 160'(bus.ioctl_wait), 160'(0));
      check("mr_count", 160'(code_count), 160'(0));
      check("mr_er", 160'(engine_reset), 160'(0));
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("mr_no_er", 160'(engine_reset), 160'(0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cheat_loader.md
# cheat_loader

Sequencer that feeds the 16-bit cheat download stream from the HPS into the 32/16 cheat engine. It clears the engine when a download starts, assembles every 16 bytes into one 128-bit code, reorders the fields into the engine's big-endian layout, and strobes the engine's code clock bit once per completed code. It sits between the ioctl download port and the cheat engine's `reset`/`code` inputs, and back-pressures the host with `ioctl_wait` while a code is being strobed.

## Interface
- `MAX_CODES`, 32: engine capacity; codes beyond this are dropped.
- `CLEAR_CYCLES`, 4: cycles `engine_reset` is held at download start (≥1).
- `HOLD_CYCLES`, 2: cycles `code[128]` stays high, and then stays low, per strobe (≥1).
- `IOADDR_WIDTH`, 25: width of `ioctl_addr`.

- `clk`  in  1  system clock; the engine runs on the same clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cheat_download`  in  1  high while the cheat file is being downloaded.
- `ioctl_wr`  in  1  single-cycle write strobe.
- `ioctl_addr`  in  IOADDR_WIDTH  byte address within the file; always even.
- `ioctl_dout`  in  16  data word; the low byte is the earlier file byte.
- `ioctl_wait`  out  1  host must hold off writes while this is high.
- `engine_reset`  out  1  drives the engine's `reset`.
- `code`  out  129  drives the engine's `code` input.
- `code_count`  out  $clog2(MAX_CODES+1)  number of codes delivered to the engine.
- `overflow`  out  1  sticky; set when a code beyond `MAX_CODES` is dropped.

## Operation
- The states are IDLE, CLEAR, COLLECT, STB_HI and STB_LO.
- A rising edge of `cheat_download` is detected with a registered copy. It is taken from any state and moves to CLEAR.
  - It clears `code_count`, `overflow`, the assembly buffer and `code[128]`.
- CLEAR:
  - `engine_reset` is held at 1 for CLEAR_CYCLES.
  - The next state is COLLECT if `cheat_download` is still high, otherwise IDLE.
  - `ioctl_wait` is 1 in this state.
- COLLECT: on `ioctl_wr`, the word index is w = `ioctl_addr[3:1]`.
  - Field f = w>>1: 0 is flags, 1 is address, 2 is compare, 3 is replace.
  - Even w writes bits [15:0] of the field; odd w writes bits [31:16]. This gives field = {b3,b2,b1,b0} from file bytes b0..b3.
  - Fields are placed at `code[127:96]` (flags), `code[95:64]` (address), `code[63:32]` (compare) and `code[31:0]` (replace).
  - A write with w = 7 completes the code.
    - If `code_count` < MAX_CODES, go to STB_HI.
    - Otherwise set `overflow`, stay in COLLECT, and leave the count unchanged.
- STB_HI: `code[128]` = 1 for HOLD_CYCLES, then go to STB_LO.
- STB_LO:
  - `code[128]` = 0 for HOLD_CYCLES.
  - `code_count` increments on entry.
  - The next state is COLLECT if `cheat_download` is high, otherwise IDLE.
- `code[127:0]` is stable from entry to STB_HI until the next write in COLLECT.
- A falling edge of `cheat_download` in COLLECT goes to IDLE, and any partial code is discarded.
- A falling edge during STB_HI or STB_LO lets the strobe complete, so the last code is delivered.
- `ioctl_wr` is ignored in IDLE, CLEAR, STB_HI and STB_LO.
- Word indices need not arrive in order. Only the w = 7 write triggers the strobe, so file codes are exactly 16 bytes.

## Timing
- Reset values (all outputs):
  - state = IDLE.
  - `ioctl_wait` = 0, `engine_reset` = 0, `code` = 0, `code_count` = 0, `overflow` = 0.
- All outputs are registered.
- Download start:
  - `cheat_download` rises in cycle T.
  - `engine_reset` = 1 in cycles T+1 .. T+CLEAR_CYCLES.
  - `ioctl_wait` = 1 over the same cycles.
  - COLLECT is entered at T+CLEAR_CYCLES+1.
- Strobe:
  - The w = 7 write is in cycle T.
  - `ioctl_wait` = 1 and `code[128]` = 1 from T+1 to T+HOLD_CYCLES.
  - `code[128]` = 0 from T+HOLD_CYCLES+1 to T+2·HOLD_CYCLES.
  - `code_count` updates at T+HOLD_CYCLES+1.
  - `ioctl_wait` falls at T+2·HOLD_CYCLES+1.
- Minimum per-code period is 8 writes + 2·HOLD_CYCLES cycles.
- A new `cheat_download` rising edge during STB_HI forces `code[128]` to 0 on the next cycle.
- `reset_n` asserted mid-operation returns all outputs to their reset values immediately. No engine reset is issued until the next download start.

## Test plan
- Reset, then download start:
  - Required: `engine_reset` high for exactly 4 cycles; `ioctl_wait` coincident with it.
  - Required: `code_count` = 0 and `overflow` = 0.
- One code with bytes 00..0F:
  - `code[127:0]` = 0x03020100_07060504_0B0A0908_0F0E0D0C.
  - `code[128]` high for 2 cycles, then low for 2; `code_count` = 1.
- 33 codes with MAX_CODES = 32:
  - Required: exactly 32 strobes; `code_count` = 32; `overflow` = 1 after the 33rd code.
- 12 bytes (6 words), then `cheat_download` falls:
  - Required: no strobe, `code_count` unchanged, state IDLE.
- `ioctl_wr` issued while `ioctl_wait` is high:
  - Required: the write is ignored, the buffer is unchanged, and the strobe timing is unaffected.
- Second download while a strobe is in progress:
  - Required: `code[128]` drops the next cycle; `engine_reset` pulses for 4 cycles; `code_count` returns to 0.
